// File: rtl/jtag_dmi_target.sv
// DMI request consumer: runs each DMI read/write as one transaction on a
// request/grant/response register bus, with a bus timeout and failure counter.
module jtag_dmi_target #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] dmi_addr,
  input  logic [DATA_WIDTH-1:0] dmi_wdata,
  input  logic [1:0]            dmi_op,
  input  logic                  dmi_req_valid,
  output logic                  dmi_req_ready,
  output logic [DATA_WIDTH-1:0] dmi_rdata,
  output logic [1:0]            dmi_resp,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_err,
  output logic [7:0]            fail_count
);
  // state    | meaning
  // ST_IDLE  | ready for a DMI request
  // ST_REQ   | bus_req held, waiting for grant (rvalid with grant completes)
  // ST_RSP   | granted, waiting for rvalid
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_e;

  localparam int unsigned CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_BUSY = 2'd3;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            fail_q, fail_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  complete, fail_inc;

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fail_d   = fail_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    fail_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dmi_req_valid && ready_q) begin
          if (dmi_op == OP_NOP) begin
            resp_d = RESP_OK;
          end else if (dmi_op == OP_READ || dmi_op == OP_WRITE) begin
            req_d   = 1'b1;
            we_d    = (dmi_op == OP_WRITE);
            addr_d  = dmi_addr;
            wdata_d = dmi_wdata;
            ready_d = 1'b0;
            resp_d  = RESP_BUSY;
            cnt_d   = '0;
            state_d = ST_REQ;
          end else begin
            resp_d   = RESP_FAIL;
            fail_inc = 1'b1;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_gnt) begin
          req_d = 1'b0;
          if (bus_rvalid) complete = 1'b1;
          else            state_d  = ST_RSP;
        end
      end
      ST_RSP: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_rvalid) complete = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion takes priority over a timeout landing in the same cycle.
    if (complete) begin
      if (!we_q && !bus_err) rdata_d = bus_rdata;
      resp_d   = bus_err ? RESP_FAIL : RESP_OK;
      fail_inc = bus_err;
      ready_d  = 1'b1;
      state_d  = ST_IDLE;
    end else if (TIMEOUT_CYCLES != 0 && state_q != ST_IDLE && cnt_q == CW'(LAST)) begin
      req_d    = 1'b0;
      resp_d   = RESP_FAIL;
      fail_inc = 1'b1;
      ready_d  = 1'b1;
      state_d  = ST_IDLE;
    end

    if (fail_inc && fail_q != 8'hFF) fail_d = fail_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      rdata_q <= '0;
      resp_q  <= RESP_OK;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmi_req_ready = ready_q;
  assign dmi_rdata     = rdata_q;
  assign dmi_resp      = resp_q;
  assign bus_req       = req_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign fail_count    = fail_q;

endmodule

// File: tb/tb_jtag_dmi_target.sv
// Directed plus randomized bench for jtag_dmi_target against a transaction-level
// model: outcome derived from grant/response delays versus the timeout budget.
module tb_jtag_dmi_target;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] dmi_addr;
  logic [DW-1:0] dmi_wdata;
  logic [1:0]    dmi_op;
  logic          dmi_req_valid;
  logic          dmi_req_ready;
  logic [DW-1:0] dmi_rdata;
  logic [1:0]    dmi_resp;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_gnt, bus_rvalid, bus_err;
  logic [DW-1:0] bus_rdata;
  logic [7:0]    fail_count;

  jtag_dmi_target #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_op(dmi_op),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_rdata(dmi_rdata), .dmi_resp(dmi_resp),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_resp;
  int            m_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_fail();
    if (m_fail < 255) m_fail++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, dmi_req_ready, 1'b1);
    chk({tag, "_bus_req"}, bus_req, 1'b0);
    chk({tag, "_resp"}, dmi_resp, m_resp);
    chk({tag, "_rdata"}, dmi_rdata, m_rdata);
    chk({tag, "_fail"}, fail_count, m_fail);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, dmi_req_ready, 1'b1);
    chk({tag, "_rdata"}, dmi_rdata, '0);
    chk({tag, "_resp"}, dmi_resp, 2'd0);
    chk({tag, "_bus_req"}, bus_req, 1'b0);
    chk({tag, "_bus_we"}, bus_we, 1'b0);
    chk({tag, "_bus_addr"}, bus_addr, '0);
    chk({tag, "_bus_wdata"}, bus_wdata, '0);
    chk({tag, "_fail"}, fail_count, 8'd0);
  endtask

  // NOP or reserved op; caller is at a negedge, returns at a negedge.
  task automatic simple(input logic [1:0] op, input string tag);
    dmi_op = op; dmi_addr = AW'($urandom); dmi_wdata = $urandom; dmi_req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    dmi_req_valid = 1'b0;
    if (op == 2'd3) begin m_resp = 2'd2; model_fail(); end
    else m_resp = 2'd0;
    check_idle(tag);
  endtask

  // READ/WRITE: grant at g cycles after bus_req rises, rvalid r cycles after grant.
  task automatic txn(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input int g, input int r, input bit err, input logic [DW-1:0] rd,
                     input bit noise, input string tag);
    int  k;
    int  done_k;
    bit  completes;
    dmi_op = op; dmi_addr = a; dmi_wdata = wd; dmi_req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    dmi_req_valid = 1'b0; dmi_addr = AW'($urandom); dmi_wdata = $urandom;
    chk({tag, "_acc_req"}, bus_req, 1'b1);
    chk({tag, "_acc_addr"}, bus_addr, a);
    chk({tag, "_acc_we"}, bus_we, (op == 2'd2));
    chk({tag, "_acc_wdata"}, bus_wdata, wd);
    chk({tag, "_acc_ready"}, dmi_req_ready, 1'b0);
    completes = (g + r < TO);
    done_k    = completes ? g + r + 1 : TO;
    k = 0;
    while (dmi_req_ready !== 1'b1 && k < 40) begin
      chk({tag, "_busy"}, dmi_resp, 2'd3);
      if (k <= g) begin
        chk({tag, "_hold_req"}, bus_req, 1'b1);
        chk({tag, "_hold_addr"}, bus_addr, a);
        chk({tag, "_hold_wdata"}, bus_wdata, wd);
      end else begin
        chk({tag, "_rsp_req"}, bus_req, 1'b0);
      end
      bus_gnt       = (k == g);
      bus_rvalid    = (k == g + r) || (noise && k == g - 1);
      bus_err       = err;
      bus_rdata     = (k == g + r) ? rd : $urandom;
      dmi_req_valid = noise;
      @(posedge clk); @(negedge clk);
      k++;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; dmi_req_valid = 1'b0;
    if (completes) begin
      if (op == 2'd1 && !err) m_rdata = rd;
      m_resp = err ? 2'd2 : 2'd0;
    end else begin
      m_resp = 2'd2;
    end
    if (m_resp == 2'd2) model_fail();
    chk({tag, "_latency"}, k, done_k);
    check_idle(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    dmi_addr = '0; dmi_wdata = '0; dmi_op = 2'd0; dmi_req_valid = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    m_rdata = '0; m_resp = 2'd0; m_fail = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    txn(2'd1, 7'h11, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0, "rd_fast");
    txn(2'd2, 7'h10, 32'h1, 3, 2, 1'b0, 32'h12345678, 1'b0, "wr_slow");
    txn(2'd1, 7'h22, 32'h0, 1, 0, 1'b1, 32'hBAD0BAD0, 1'b0, "rd_err");
    chk("rd_err_fail1", fail_count, 8'd1);
    txn(2'd1, 7'h05, 32'h0, 99, 0, 1'b0, 32'h0, 1'b0, "tmo");

    // late response and stray grant in IDLE must be ignored
    bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_err = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    bus_rvalid = 1'b0; bus_gnt = 1'b0; bus_err = 1'b0;
    check_idle("late_rvalid");

    simple(2'd0, "nop");
    simple(2'd3, "rsvd");
    for (int i = 0; i < 300; i++) simple(2'd3, "rsvd_sat");
    chk("fail_saturated", fail_count, 8'd255);

    // reset while waiting for rvalid
    dmi_op = 2'd1; dmi_addr = 7'h33; dmi_wdata = '0; dmi_req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    dmi_req_valid = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_gnt = 1'b0;
    chk("rsp_bus_req", bus_req, 1'b0);
    chk("rsp_busy", dmi_resp, 2'd3);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    m_rdata = '0; m_resp = 2'd0; m_fail = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
    @(posedge clk); @(negedge clk);
    bus_rvalid = 1'b0;
    check_idle("post_reset");
    txn(2'd1, 7'h44, 32'h0, 2, 1, 1'b0, 32'hA5A5_0F0F, 1'b0, "post_reset_rd");

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'd0 || op == 2'd3) simple(op, "rnd_simple");
      else txn(op, AW'($urandom), $urandom, $urandom_range(0, 9), $urandom_range(0, 4),
               ($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 1)), "rnd_txn");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtag_dmi_target.md
Name: jtag_dmi_target

Overview:
- Downstream consumer of the JTAG DTM's DMI request port. Accepts one DMI request at a time through a valid/ready handshake.
- Executes each read or write as a single transaction on a simple request/grant/response register bus towards the Debug Module register file.
- Returns read data and a DMI response code, enforcing a bus timeout.
- Runs in the same clock domain as the DMI port it connects to.

Parameters:
- ADDR_WIDTH, 7, DMI address width; equals DMI_ADDR_WIDTH from jtag_dmi_pkg.
- DATA_WIDTH, 32, DMI data width; equals DMI_DATA_WIDTH.
- TIMEOUT_CYCLES, 255, max cycles from bus_req assertion to bus_rvalid; 0 disables the timeout.

Ports:
- clk  input  1  Block clock.
- rst_n  input  1  Asynchronous active-low reset.
- dmi_addr  input  ADDR_WIDTH  Request address.
- dmi_wdata  input  DATA_WIDTH  Request write data.
- dmi_op  input  2  0=NOP, 1=READ, 2=WRITE, 3=reserved.
- dmi_req_valid  input  1  Request valid.
- dmi_req_ready  output  1  Request accepted when high together with valid.
- dmi_rdata  output  DATA_WIDTH  Last read data.
- dmi_resp  output  2  0=success, 2=failed, 3=busy.
- bus_req  output  1  Register-bus request.
- bus_we  output  1  1=write, 0=read.
- bus_addr  output  ADDR_WIDTH  Bus address.
- bus_wdata  output  DATA_WIDTH  Bus write data.
- bus_gnt  input  1  Request granted.
- bus_rvalid  input  1  Response valid.
- bus_rdata  input  DATA_WIDTH  Response read data.
- bus_err  input  1  Response error; qualified by bus_rvalid.
- fail_count  output  8  Saturating count of failed responses.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - dmi_req_ready=1, dmi_rdata=0, dmi_resp=0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - fail_count=0, timeout counter=0.
  - Reset asserted mid-transaction abandons it; no bus response is awaited after release.
- All outputs are registered.
- States: IDLE, REQ, RSP.
- IDLE:
  - dmi_req_ready=1. A request is accepted only on the cycle where dmi_req_valid and dmi_req_ready are both high.
  - NOP accepted: dmi_resp<=0, dmi_rdata unchanged, stay IDLE.
  - Reserved op accepted: dmi_resp<=2, fail_count increments, stay IDLE.
  - READ/WRITE accepted: latch addr/wdata/we into the bus_* registers, bus_req<=1, dmi_req_ready<=0, dmi_resp<=3, go to REQ.
- REQ:
  - bus_req, bus_we, bus_addr and bus_wdata stay stable until bus_req & bus_gnt.
  - On grant, bus_req<=0. If bus_rvalid is also high that cycle, complete immediately (see completion). Otherwise go to RSP.
- RSP: wait for bus_rvalid. bus_gnt is ignored here.
- Completion (first bus_rvalid at or after grant):
  - READ without error: dmi_rdata<=bus_rdata.
  - WRITE, or any error: dmi_rdata unchanged.
  - dmi_resp<=bus_err?2:0.
  - dmi_req_ready<=1, go to IDLE.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ/RSP.
  - Reaching TIMEOUT_CYCLES without completion: bus_req<=0, dmi_resp<=2, fail_count increments, go to IDLE.
  - A late bus_rvalid arriving in IDLE is ignored.
  - Completion and timeout in the same cycle: completion wins.
- fail_count increments once per resp=2 outcome and saturates at 255.
- Inputs ignored outside their qualifying state:
  - dmi_req_valid while ready=0.
  - bus_gnt while bus_req=0.
  - bus_rvalid in IDLE or in REQ before grant.
- Minimum latency:
  - Accept at cycle T, bus_req high at T+1.
  - With gnt and rvalid both high at T+1, dmi_resp/dmi_rdata are updated and ready is high at T+2.
- Throughput: back-to-back requests are accepted from T+2.

Test Plan:
- Reset, then READ addr 0x11 with bus_gnt/bus_rvalid same cycle and bus_rdata=0xDEADBEEF -> bus_addr=0x11, bus_we=0; dmi_rdata=0xDEADBEEF and dmi_resp=0 at T+2; ready high at T+2.
- WRITE addr 0x10 data 0x1 with gnt delayed 3 cycles and rvalid 2 cycles later -> bus_* stable through the wait; dmi_resp=3 during the transaction, then 0; dmi_rdata unchanged.
- READ with bus_rvalid and bus_err=1 -> dmi_resp=2, dmi_rdata holds previous value, fail_count=1.
- TIMEOUT_CYCLES=8, bus_gnt never asserted -> bus_req drops after 8 cycles, dmi_resp=2, back in IDLE; a later bus_rvalid has no effect.
- NOP then op=3 -> resp 0 then 2, dmi_req_ready never deasserts, no bus_req; 300 reserved ops -> fail_count saturates at 255.
- rst_n pulsed low while in RSP -> all outputs return to reset values immediately; a following READ completes normally.
